// File: rtl/coin_feeder.sv
// coin_feeder
//   Buys a batch of drinks from a vending machine (price 2.0, i.e. four
//   half-units) by feeding coins in one of several payment patterns.
//   The drink and change responses from the machine are collected.
//   An order can be cancelled while paying; in that case the machine is
//   asked for a refund.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-high reset
//   start         order request, sampled only in IDLE
//   cnt           number of drinks to buy, latched on an accepted start
//   mode          payment pattern, latched on an accepted start
//   cancel        abort request, sampled only in PAY
//   drink         registered drink pulse from the machine
//   back          registered change code from the machine (half-units)
//   coin          coin to the machine: 00 none, 01 = 0.5, 10 = 1.0, 11 refund
//   busy          high while an order is in progress
//   done          one-cycle completion pulse
//   drinks_got    drinks received in the current order
//   change_total  change received in half-units, saturating at 31
//   err           sticky, set when an expected drink did not arrive
module coin_feeder #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] cnt,
  input  logic [1:0]       mode,
  input  logic             cancel,
  input  logic             drink,
  input  logic [1:0]       back,
  output logic [1:0]       coin,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] drinks_got,
  output logic [4:0]       change_total,
  output logic             err
);

  typedef enum logic [2:0] {
    IDLE,
    PAY,
    WAIT,
    REFUND,
    RWAIT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       mode_q;
  logic [1:0]       idx;
  logic [1:0]       pat_coin;
  logic             pat_last;
  logic [CNT_W-1:0] drinks_inc;

  // The back code value equals the change in half-units, so it is added
  // directly.
  function automatic logic [4:0] sat_add(input logic [4:0] a, input logic [1:0] b);
    logic [5:0] s;
    s = {1'b0, a} + {4'b0000, b};
    return s[5] ? 5'd31 : s[4:0];
  endfunction

  assign drinks_inc = drinks_got + CNT_W'(1);

  // Coin pattern for one drink, indexed by the coin position within that drink.
  // Modes 00 and 11 both pay with two 1.0 coins.
  always_comb begin
    pat_coin = 2'b10;
    pat_last = 1'b0;
    case (mode_q)
      2'b01: begin
        pat_coin = 2'b01;
        pat_last = (idx == 2'd3);
      end
      2'b10: begin
        pat_coin = (idx == 2'd0) ? 2'b01 : 2'b10;
        pat_last = (idx == 2'd2);
      end
      default: begin
        pat_coin = 2'b10;
        pat_last = (idx == 2'd1);
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // The machine answers one cycle after the completing coin, so WAIT and
  // RWAIT are single cycles. In these cycles drink and back are sampled.
  always_comb begin
    state_nxt = state;
    coin      = 2'b00;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (cnt != '0) ? PAY : DONE;
      end
      PAY: begin
        busy = 1'b1;
        coin = pat_coin;
        if (cancel)        state_nxt = REFUND;
        else if (pat_last) state_nxt = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (!drink)                  state_nxt = DONE;
        else if (drinks_inc == cnt_q) state_nxt = DONE;
        else                         state_nxt = PAY;
      end
      REFUND: begin
        busy      = 1'b1;
        coin      = 2'b11;
        state_nxt = RWAIT;
      end
      RWAIT: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Order bookkeeping. Results stay visible in IDLE until the next accepted
  // order. An order with cnt=0 leaves them untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      mode_q       <= 2'b00;
      idx          <= 2'd0;
      drinks_got   <= '0;
      change_total <= 5'd0;
      err          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (cnt != '0)) begin
            cnt_q        <= cnt;
            mode_q       <= mode;
            idx          <= 2'd0;
            drinks_got   <= '0;
            change_total <= 5'd0;
            err          <= 1'b0;
          end
        end
        PAY: begin
          if (!cancel) idx <= idx + 2'd1;
        end
        WAIT: begin
          idx <= 2'd0;
          if (drink) begin
            drinks_got   <= drinks_inc;
            change_total <= sat_add(change_total, back);
          end else begin
            err <= 1'b1;
          end
        end
        REFUND: begin
          // The coin inserted in the cancel cycle may itself have completed a drink.
          if (drink) begin
            drinks_got   <= drinks_inc;
            change_total <= sat_add(change_total, back);
          end
        end
        RWAIT: begin
          change_total <= sat_add(change_total, back);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_coin_feeder.sv
// tb_coin_feeder
//   Self-checking bench for coin_feeder. A behavioural vending machine
//   answers the coins. A reference model predicts, for each order, the coin
//   seen on every cycle and the final drinks/change/err values.
module tb_coin_feeder;

  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] cnt;
  logic [1:0]    mode;
  logic          cancel;
  logic          drink;
  logic [1:0]    back;
  logic [1:0]    coin;
  logic          busy;
  logic          done;
  logic [CW-1:0] drinks_got;
  logic [4:0]    change_total;
  logic          err;

  int errors = 0;
  int checks = 0;

  int vm_credit;
  int vm_sales;
  int vm_withhold_at;

  int         exp_drinks;
  int         exp_change;
  int         exp_err;
  logic [1:0] exp_coin[$];
  int         cancel_idx;

  coin_feeder #(.CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .cnt          (cnt),
    .mode         (mode),
    .cancel       (cancel),
    .drink        (drink),
    .back         (back),
    .coin         (coin),
    .busy         (busy),
    .done         (done),
    .drinks_got   (drinks_got),
    .change_total (change_total),
    .err          (err)
  );

  always #5 clk = ~clk;

  function automatic int add_coin(input int credit, input logic [1:0] c);
    return credit + ((c == 2'b01) ? 1 : (c == 2'b10) ? 2 : 0);
  endfunction

  // Vending machine: sells at 4 half-units, returns the excess as change,
  // refunds the held credit on coin 11, and can withhold one chosen sale.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      vm_credit <= 0;
      vm_sales  <= 0;
      drink     <= 1'b0;
      back      <= 2'b00;
    end else begin
      drink <= 1'b0;
      back  <= 2'b00;
      if (coin == 2'b11) begin
        back      <= 2'((vm_credit > 3) ? 3 : vm_credit);
        vm_credit <= 0;
      end else if (add_coin(vm_credit, coin) >= 4) begin
        if (vm_sales != vm_withhold_at) begin
          drink <= 1'b1;
          back  <= 2'(add_coin(vm_credit, coin) - 4);
        end
        vm_sales  <= vm_sales + 1;
        vm_credit <= 0;
      end else begin
        vm_credit <= add_coin(vm_credit, coin);
      end
    end
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " done"}, int'(done), 0);
    checkOutput({tag, " busy"}, int'(busy), 0);
    checkOutput({tag, " coin"}, int'(coin), 0);
    checkOutput({tag, " drinks_got"}, int'(drinks_got), exp_drinks);
    checkOutput({tag, " change_total"}, int'(change_total), exp_change);
    checkOutput({tag, " err"}, int'(err), exp_err);
  endtask

  // Runs one order. cancel_k is the order-wide coin number to cancel on
  // (-1 for none). withhold_w is the drink number the machine withholds
  // (0 for none).
  task automatic applyStimulus(input int n, input int m, input int cancel_k, input int withhold_w);
    int  pat[$];
    int  partial;
    int  g;
    bit  stopped;
    bit  last;
    if (m == 1)      pat = '{1, 1, 1, 1};
    else if (m == 2) pat = '{1, 2, 2};
    else             pat = '{2, 2};
    exp_coin.delete();
    cancel_idx = -1;
    g          = 0;
    stopped    = 1'b0;
    if (n != 0) begin
      exp_drinks = 0;
      exp_change = 0;
      exp_err    = 0;
      for (int d = 0; d < n && !stopped; d++) begin
        partial = 0;
        for (int p = 0; p < pat.size() && !stopped; p++) begin
          exp_coin.push_back(2'(pat[p]));
          partial += pat[p];
          if (g == cancel_k) begin
            cancel_idx = exp_coin.size() - 1;
            if (p == pat.size() - 1) begin
              exp_drinks++;
              exp_change += partial - 4;
            end else begin
              exp_change += partial;
            end
            exp_coin.push_back(2'b11);
            exp_coin.push_back(2'b00);
            stopped = 1'b1;
          end
          g++;
        end
        if (!stopped) begin
          exp_coin.push_back(2'b00);
          if (d + 1 == withhold_w) begin
            exp_err = 1;
            stopped = 1'b1;
          end else begin
            exp_drinks++;
            exp_change += partial - 4;
          end
        end
      end
      if (exp_change > 31) exp_change = 31;
    end
    exp_coin.push_back(2'b00);

    @(negedge clk);
    vm_withhold_at = (withhold_w > 0) ? vm_sales + withhold_w - 1 : -1;
    start  = 1'b1;
    cnt    = CW'(n);
    mode   = 2'(m);
    cancel = 1'($urandom % 2);
    for (int j = 0; j < exp_coin.size(); j++) begin
      last = (j == exp_coin.size() - 1);
      @(negedge clk);
      checkOutput($sformatf("n%0d m%0d coin@%0d", n, m, j), int'(coin), int'(exp_coin[j]));
      checkOutput($sformatf("n%0d m%0d busy@%0d", n, m, j), int'(busy), int'(!last));
      checkOutput($sformatf("n%0d m%0d done@%0d", n, m, j), int'(done), int'(last));
      start = 1'($urandom % 2);
      cnt   = CW'($urandom);
      mode  = 2'($urandom);
      if (j == cancel_idx)
        cancel = 1'b1;
      else if (exp_coin[j] == 2'b01 || exp_coin[j] == 2'b10)
        cancel = 1'b0;
      else
        cancel = 1'($urandom % 2);
    end
    @(negedge clk);
    start  = 1'b0;
    cancel = 1'b0;
    checkIdle($sformatf("n%0d m%0d end", n, m));
  endtask

  // Reset arrives while the second half-coin of a mode 01 order is on the bus.
  task automatic applyResetMidOrder();
    @(negedge clk);
    start = 1'b1;
    cnt   = CW'(1);
    mode  = 2'b01;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checkOutput("pre-reset coin", int'(coin), 1);
    reset = 1'b1;
    #1;
    exp_drinks = 0;
    exp_change = 0;
    exp_err    = 0;
    checkIdle("mid-reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int n;
    int m;
    int len;
    int k;
    int w;
    reset          = 1'b1;
    start          = 1'b0;
    cancel         = 1'b0;
    cnt            = '0;
    mode           = 2'b00;
    vm_withhold_at = -1;
    exp_drinks     = 0;
    exp_change     = 0;
    exp_err        = 0;
    repeat (3) @(negedge clk);
    checkIdle("reset");
    reset = 1'b0;

    applyStimulus(2, 0, -1, 0);
    applyStimulus(1, 2, -1, 0);
    applyResetMidOrder();
    applyStimulus(1, 0, -1, 0);
    applyStimulus(1, 1, 2, 0);
    applyStimulus(1, 0, -1, 1);
    applyStimulus(0, 0, -1, 0);
    applyStimulus(31, 2, -1, 0);
    applyStimulus(31, 2, 91, 0);
    applyStimulus(3, 3, 5, 0);

    for (int i = 0; i < 40; i++) begin
      n   = $urandom_range(0, 6);
      m   = $urandom_range(0, 3);
      len = (m == 1) ? 4 : (m == 2) ? 3 : 2;
      k   = -1;
      w   = 0;
      if (n > 0 && ($urandom % 3) == 0)
        k = $urandom_range(0, n * len - 1);
      else if (n > 0 && ($urandom % 4) == 0)
        w = $urandom_range(1, n);
      applyStimulus(n, m, k, w);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/coin_feeder.md
COIN_FEEDER -- requirements
Module: coin_feeder

Interface
REQ-001 SHALL have parameter CNT_W, default 3, width of order count and drink tally.
REQ-002 SHALL have port clk, input, 1, rising-edge clock.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1, single-cycle order request, sampled only in IDLE.
REQ-005 SHALL have port cnt, input, CNT_W, number of drinks to buy, latched on accepted start.
REQ-006 SHALL have port mode, input, 2, payment pattern, latched on accepted start.
REQ-007 SHALL have port cancel, input, 1, abort request, sampled only in PAY.
REQ-008 SHALL have port drink, input, 1, registered drink pulse from vending machine.
REQ-009 SHALL have port back, input, 2, registered change code from vending machine: 01 = 0.5, 10 = 1.0, 11 = 1.5.
REQ-010 SHALL have port coin, output, 2, coin to vending machine: 00 none, 01 = 0.5, 10 = 1.0, 11 refund request.
REQ-011 SHALL have port busy, output, 1, high in PAY, WAIT, REFUND and RWAIT.
REQ-012 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-013 SHALL have port drinks_got, output, CNT_W, drinks received in current order.
REQ-014 SHALL have port change_total, output, 5, change received in half-units, saturating at 31.
REQ-015 SHALL have port err, output, 1, sticky, set when an expected drink is missing.

Function
REQ-016 SHALL implement states IDLE, PAY, WAIT, REFUND, RWAIT and DONE.
REQ-017 SHALL drive coin combinationally from state: PAY gives the pattern coin, REFUND gives 11, all other states give 00.
REQ-018 SHALL use price = 2.0 (4 half-units); vending machine samples coin on every rising edge, and drink/back are valid the cycle after the completing coin.
REQ-019 SHALL use coin sequence per drink: mode 00 or 11 = 10,10; mode 01 = 01,01,01,01; mode 10 = 01,10,10 (expects back = 01).
REQ-020 SHALL, in IDLE with start=1 and cnt!=0, latch cnt and mode, clear drinks_got, change_total, err and coin index, and go to PAY.
REQ-021 SHALL, in IDLE with start=1 and cnt=0, go to DONE without inserting coins.
REQ-022 SHALL, in PAY with cancel=0, advance the coin index each cycle and go to WAIT after the last coin of the pattern.
REQ-023 SHALL, in PAY with cancel=1, count the coin driven that cycle as inserted and go to REFUND.
REQ-024 SHALL, at the end of WAIT with drink=1, increment drinks_got, add the back value to change_total, and reset the coin index.
REQ-025 SHALL, after that WAIT, go to DONE when drinks_got reaches the latched cnt, else to PAY.
REQ-026 SHALL, at the end of WAIT with drink=0, set err and go to DONE.
REQ-027 SHALL, at the end of REFUND, count drink=1 if present (last coin completed a drink) and add its back value, then go to RWAIT.
REQ-028 SHALL, at the end of RWAIT, add the back value to change_total and go to DONE.
REQ-029 SHALL, in DONE, assert done=1 and busy=0 for exactly one cycle, then return to IDLE.
REQ-030 SHALL hold drinks_got, change_total and err unchanged in IDLE until the next accepted start.
REQ-031 SHALL ignore start while busy, and ignore cancel outside PAY.
REQ-032 SHALL saturate change_total at 31, with no wrap.

Reset
REQ-033 SHALL, on reset=1 at any time (including mid-order), immediately force state IDLE, coin=00, busy=0, done=0, drinks_got=0, change_total=0, err=0, and clear the coin index and latched cnt/mode.
REQ-034 SHALL resume normal operation on the first rising clk edge after reset deasserts.

Verification
REQ-035 SHALL cover: cnt=2, mode=00 -> coin 10,10,00,10,10,00; drinks_got=2, change_total=0, done pulse, err=0.
REQ-036 SHALL cover: cnt=1, mode=10 -> coin 01,10,10,00; drink with back=01; drinks_got=1, change_total=1.
REQ-037 SHALL cover: cnt=1, mode=01, cancel on the 3rd coin -> coin 01,01,01,11,00; back=11; drinks_got=0, change_total=3.
REQ-038 SHALL cover: cnt=1, mode=00, machine model withholding drink -> err=1, done pulse, drinks_got=0.
REQ-039 SHALL cover: reset asserted mid-PAY during the 2nd half-coin -> coin=00 the same cycle, all outputs 0; a new start then proceeds normally.
REQ-040 SHALL cover: start with cnt=0 -> done on the next cycle, coin stays 00, busy stays 0.
